// File: rtl/cmos_pkg.sv
// Shared definitions for the camera capture path: state encoding, default
// geometry (kept in step with vga_control) and a saturating counter helper.
package cmos_pkg;

   typedef enum logic [1:0] {
      S_SKIP = 2'd0,
      S_WAIT = 2'd1,
      S_CAP  = 2'd2
   } cap_state_t;

   localparam int H_DEFAULT    = 640;
   localparam int V_DEFAULT    = 480;
   localparam int RGB_W        = 16;
   localparam int SKIP_DEFAULT = 10;
   localparam int CNT_W        = 11;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/cmos_edge_det.sv
// Registers one DVP control line and produces single-cycle rise/fall pulses
// aligned with the registered copy.
module cmos_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= 1'b0;
         q_d <= 1'b0;
      end else begin
         q   <= din;
         q_d <= q;
      end
   end

   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/cmos_capture.sv
// DVP camera capture: drops start-up frames, assembles RGB565 from byte pairs
// and pushes one word per pixel into the SDRAM write FIFO with frame markers.
module cmos_capture
   import cmos_pkg::*;
#(
   parameter int H_PIXELS    = H_DEFAULT,
   parameter int V_LINES     = V_DEFAULT,
   parameter int SKIP_FRAMES = SKIP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_data,
   input  logic        capture_en,
   output logic        wr_en,
   output logic [15:0] wr_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        frame_err
);

   localparam logic [CNT_W-1:0] H_L    = CNT_W'(H_PIXELS);
   localparam logic [CNT_W-1:0] V_L    = CNT_W'(V_LINES);
   localparam logic [3:0]       SKIP_L = 4'(SKIP_FRAMES);

   logic r_vsync, vs_rise, vs_fall;
   logic r_href, href_rise, href_fall;
   logic [7:0] r_data;

   cmos_edge_det u_vs (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (cmos_vsync),
      .q    (r_vsync),
      .rise (vs_rise),
      .fall (vs_fall)
   );

   cmos_edge_det u_hs (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (cmos_href),
      .q    (r_href),
      .rise (href_rise),
      .fall (href_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_data <= 8'h00;
      else        r_data <= cmos_data;
   end

   cap_state_t       state;
   logic [3:0]       skip_cnt;
   logic [CNT_W-1:0] pix_cnt, line_cnt;
   logic             toggle, err;
   logic [7:0]       hi_byte;
   logic             pend_en;
   logic [15:0]      pend_data;

   // A line always opens on a high byte, whatever state the toggle was left in.
   logic tog_eff;
   assign tog_eff = toggle & ~href_rise;

   // A line closing in the same cycle as vsync rises still counts toward the frame.
   logic             line_err_now;
   logic [CNT_W-1:0] lines_now;
   assign line_err_now = href_fall & ((pix_cnt != H_L) | toggle);
   assign lines_now    = href_fall ? sat_inc(line_cnt) : line_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_SKIP;
         skip_cnt    <= 4'd0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         toggle      <= 1'b0;
         err         <= 1'b0;
         hi_byte     <= 8'h00;
         pend_en     <= 1'b0;
         pend_data   <= 16'h0000;
         wr_en       <= 1'b0;
         wr_data     <= 16'h0000;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         pend_en     <= 1'b0;
         wr_en       <= pend_en;
         if (pend_en) wr_data <= pend_data;

         case (state)
            S_SKIP: begin
               if (skip_cnt == SKIP_L)
                  state <= S_WAIT;
               else if (vs_rise)
                  skip_cnt <= skip_cnt + 1'b1;
            end

            S_WAIT: begin
               if (vs_fall && capture_en) begin
                  frame_start <= 1'b1;
                  frame_err   <= 1'b0;
                  err         <= 1'b0;
                  pix_cnt     <= '0;
                  line_cnt    <= '0;
                  toggle      <= 1'b0;
                  state       <= S_CAP;
               end
            end

            S_CAP: begin
               if (vs_rise) begin
                  // r_href still high here means the last line was cut short.
                  frame_done <= 1'b1;
                  frame_err  <= err | line_err_now | r_href | (lines_now != V_L);
                  state      <= S_WAIT;
               end else if (href_fall) begin
                  if (line_err_now) err <= 1'b1;
                  line_cnt <= sat_inc(line_cnt);
                  pix_cnt  <= '0;
                  toggle   <= 1'b0;
               end else if (r_href) begin
                  if (!tog_eff) begin
                     hi_byte <= r_data;
                     toggle  <= 1'b1;
                  end else begin
                     toggle    <= 1'b0;
                     pend_en   <= (pix_cnt < H_L) && (line_cnt < V_L);
                     pend_data <= {hi_byte, r_data};
                     pix_cnt   <= sat_inc(pix_cnt);
                  end
               end
            end

            default: state <= S_SKIP;
         endcase
      end
   end

endmodule

// File: tb/tb_cmos_capture.sv
// Directed bench for cmos_capture with a 4x3 frame and two skipped frames.
module tb_cmos_capture;

   localparam int H = 4;
   localparam int V = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmos_vsync, cmos_href, capture_en;
   logic [7:0]  cmos_data;
   logic        wr_en, frame_start, frame_done, frame_err;
   logic [15:0] wr_data;

   cmos_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmos_vsync (cmos_vsync),
      .cmos_href  (cmos_href),
      .cmos_data  (cmos_data),
      .capture_en (capture_en),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .frame_start(frame_start),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: collects what the DUT emits; the test tasks judge it.
   int          wr_cnt, start_cnt, done_cnt, wide_cnt, first_wr_cyc, lo_cyc;
   logic        last_err;
   logic        prev_wr = 1'b0;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_cnt++;
         got_q.push_back(wr_data);
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         if (prev_wr) wide_cnt++;
      end
      prev_wr = (wr_en === 1'b1);
      if (frame_start === 1'b1) start_cnt++;
      if (frame_done === 1'b1) begin
         done_cnt++;
         last_err = frame_err;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] pix_val(input int base, input int l, input int p, input int fpx);
      if (fpx >= 0 && l == 0 && p == 0) return fpx[15:0];
      return 16'((base * 4099) ^ (l * 'h1234) ^ (p * 'h0F1D) ^ 'hA5C3);
   endfunction

   // One frame = V lines of bytes followed by a vsync pulse. Line sl carries
   // sb bytes instead of nbytes; vs_mid >= 0 raises vsync at that byte of line sl.
   task automatic send_frame(input int nbytes, input int sl, input int sb,
                             input int vs_mid, input int fpx, input int base);
      bit          trunc = 0;
      int          nb;
      logic [15:0] p;
      got_q.delete(); exp_q.delete();
      wr_cnt = 0; start_cnt = 0; done_cnt = 0; wide_cnt = 0;
      first_wr_cyc = -1; lo_cyc = -100; last_err = 1'bx;
      for (int l = 0; l < V && !trunc; l++) begin
         nb = (l == sl) ? sb : nbytes;
         for (int j = 0; j < nb; j++) begin
            p = pix_val(base, l, j / 2, fpx);
            @(negedge clk);
            cmos_href = 1'b1;
            if (l == sl && j == vs_mid) begin
               cmos_vsync = 1'b1;
               cmos_data  = p[15:8];
               trunc = 1;
               break;
            end
            cmos_data = (j % 2 == 0) ? p[15:8] : p[7:0];
            if (j % 2 == 1) begin
               if (l == 0 && j == 1) lo_cyc = cyc + 1;
               if (j / 2 < H) exp_q.push_back(p);
            end
         end
         @(negedge clk);
         cmos_href = 1'b0;
         cmos_data = 8'h00;
         repeat (2) @(negedge clk);
      end
      cmos_vsync = 1'b1;
      repeat (4) @(negedge clk);
      cmos_vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_data(input string name);
      int mism = 0;
      if (got_q.size() != exp_q.size()) mism++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) mism++;
      n_tests++;
      if (mism != 0) begin
         n_fail++;
         $display("FAIL %s: %0d words got, %0d expected, %0d mismatches", name, got_q.size(), exp_q.size(), mism);
      end
   endtask

   task automatic test_reset();
      cmos_vsync = 0; cmos_href = 0; cmos_data = 0; capture_en = 1; rst_n = 0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({wr_en, wr_data} !== 17'h0) begin
         n_fail++; $display("FAIL reset_wr: wr_en=%b wr_data=%h want 0", wr_en, wr_data);
      end
      n_tests++;
      if ({frame_start, frame_done, frame_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b%b%b want 000", frame_start, frame_done, frame_err);
      end
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   // Two frames are swallowed; the second's trailing vsync opens the first capture.
   task automatic test_skip(input string tag);
      send_frame(8, -1, 0, -1, -1, 1);
      n_tests++;
      if (wr_cnt !== 0 || start_cnt !== 0) begin
         n_fail++; $display("FAIL %s_frame1: wr=%0d start=%0d want 0 0", tag, wr_cnt, start_cnt);
      end
      send_frame(8, -1, 0, -1, -1, 2);
      n_tests++;
      if (wr_cnt !== 0 || start_cnt !== 1 || done_cnt !== 0) begin
         n_fail++; $display("FAIL %s_frame2: wr=%0d start=%0d done=%0d want 0 1 0", tag, wr_cnt, start_cnt, done_cnt);
      end
      send_frame(8, -1, 0, -1, -1, 3);
      n_tests++;
      if (wr_cnt !== 12 || done_cnt !== 1 || last_err !== 1'b0) begin
         n_fail++; $display("FAIL %s_frame3: wr=%0d done=%0d err=%b want 12 1 0", tag, wr_cnt, done_cnt, last_err);
      end
      check_data({tag, "_frame3_data"});
   endtask

   task automatic test_byte_order();
      send_frame(8, -1, 0, -1, 'hF81F, 4);
      n_tests++;
      if (got_q.size() == 0 || got_q[0] !== 16'hF81F) begin
         n_fail++; $display("FAIL byte_order: first word %h want f81f", got_q.size() ? got_q[0] : 16'hxxxx);
      end
      n_tests++;
      if (first_wr_cyc !== lo_cyc + 2) begin
         n_fail++; $display("FAIL latency: wr_en at edge %0d want %0d", first_wr_cyc, lo_cyc + 2);
      end
      n_tests++;
      if (wide_cnt !== 0 || last_err !== 1'b0) begin
         n_fail++; $display("FAIL strobe_width: wide=%0d err=%b want 0 0", wide_cnt, last_err);
      end
      check_data("byte_order_data");
   endtask

   task automatic test_long_line();
      send_frame(8, 1, 10, -1, -1, 5);
      n_tests++;
      if (wr_cnt !== 12 || done_cnt !== 1 || last_err !== 1'b1) begin
         n_fail++; $display("FAIL long_line: wr=%0d done=%0d err=%b want 12 1 1", wr_cnt, done_cnt, last_err);
      end
      check_data("long_line_data");
   endtask

   task automatic test_odd_bytes();
      send_frame(8, 2, 9, -1, -1, 6);
      n_tests++;
      if (wr_cnt !== 12 || done_cnt !== 1 || last_err !== 1'b1) begin
         n_fail++; $display("FAIL odd_bytes: wr=%0d done=%0d err=%b want 12 1 1", wr_cnt, done_cnt, last_err);
      end
      check_data("odd_bytes_data");
   endtask

   task automatic test_vs_mid();
      send_frame(8, 1, 8, 4, -1, 7);
      n_tests++;
      if (wr_cnt !== 6 || done_cnt !== 1 || last_err !== 1'b1) begin
         n_fail++; $display("FAIL vs_mid: wr=%0d done=%0d err=%b want 6 1 1", wr_cnt, done_cnt, last_err);
      end
      check_data("vs_mid_data");
      send_frame(8, -1, 0, -1, -1, 8);
      n_tests++;
      if (wr_cnt !== 12 || done_cnt !== 1 || last_err !== 1'b0) begin
         n_fail++; $display("FAIL vs_mid_next: wr=%0d done=%0d err=%b want 12 1 0", wr_cnt, done_cnt, last_err);
      end
   endtask

   task automatic test_capture_en();
      capture_en = 0;
      send_frame(8, -1, 0, -1, -1, 9);
      n_tests++;
      if (wr_cnt !== 12 || done_cnt !== 1 || start_cnt !== 0) begin
         n_fail++; $display("FAIL cen_finish: wr=%0d done=%0d start=%0d want 12 1 0", wr_cnt, done_cnt, start_cnt);
      end
      send_frame(8, -1, 0, -1, -1, 10);
      n_tests++;
      if (wr_cnt !== 0 || done_cnt !== 0 || start_cnt !== 0) begin
         n_fail++; $display("FAIL cen_idle: wr=%0d done=%0d start=%0d want 0 0 0", wr_cnt, done_cnt, start_cnt);
      end
      capture_en = 1;
      send_frame(8, -1, 0, -1, -1, 11);
      n_tests++;
      if (wr_cnt !== 0 || start_cnt !== 1) begin
         n_fail++; $display("FAIL cen_rearm: wr=%0d start=%0d want 0 1", wr_cnt, start_cnt);
      end
      send_frame(8, -1, 0, -1, -1, 12);
      n_tests++;
      if (wr_cnt !== 12 || done_cnt !== 1 || last_err !== 1'b0) begin
         n_fail++; $display("FAIL cen_resume: wr=%0d done=%0d err=%b want 12 1 0", wr_cnt, done_cnt, last_err);
      end
      check_data("cen_resume_data");
   endtask

   // Reset lands while a pixel strobe is on the output.
   task automatic test_reset_mid();
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         cmos_href = 1'b1;
         cmos_data = 8'(8'h30 + j);
      end
      @(negedge clk);
      n_tests++;
      if (wr_en !== 1'b1 || wr_data !== 16'h3031) begin
         n_fail++; $display("FAIL pre_reset_wr: wr_en=%b data=%h want 1 3031", wr_en, wr_data);
      end
      rst_n = 0;
      #1;
      n_tests++;
      if ({wr_en, wr_data, frame_start, frame_done, frame_err} !== 20'h0) begin
         n_fail++; $display("FAIL reset_mid: wr_en=%b data=%h flags=%b%b%b want all 0", wr_en, wr_data, frame_start, frame_done, frame_err);
      end
      cmos_href = 0; cmos_data = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      test_skip("rst_skip");
   endtask

   initial begin
      test_reset();
      test_skip("skip");
      test_byte_order();
      test_long_line();
      test_odd_bytes();
      test_vs_mid();
      test_capture_en();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
